// File: rtl/async_sram_phy_seq_pkg.sv
// Shared definitions for the timed async SRAM PHY: the FSM state encoding.
// The controller and the bench import this so that state is decoded identically everywhere.
package async_sram_phy_seq_pkg;

  localparam int PHY_ST_W = 2;

  typedef enum logic [PHY_ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } phy_state_e;

endpackage

// File: rtl/async_sram_phy_seq.sv
// Timed async SRAM PHY: runs one transaction at a time through programmable setup/strobe/hold
// phases, with every pad-facing output and the read response driven directly from flops.
module async_sram_phy_seq
  import async_sram_phy_seq_pkg::*;
#(
  parameter int N_SRAM_A  = 18,
  parameter int N_SRAM_DQ = 16,
  parameter int W_TIMING  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W_TIMING-1:0]    cfg_setup,
  input  logic [W_TIMING-1:0]    cfg_strobe,
  input  logic [W_TIMING-1:0]    cfg_hold,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [N_SRAM_A-1:0]    req_addr,
  input  logic [N_SRAM_DQ-1:0]   req_wdata,
  input  logic [N_SRAM_DQ/8-1:0] req_byte_n,
  output logic                   rsp_valid,
  output logic [N_SRAM_DQ-1:0]   rsp_rdata,
  input  logic [N_SRAM_DQ-1:0]   padin_sram_dq,
  output logic [N_SRAM_DQ-1:0]   padout_sram_dq,
  output logic [N_SRAM_DQ-1:0]   padoe_sram_dq,
  output logic [N_SRAM_A-1:0]    padout_sram_a,
  output logic                   padout_sram_cs_n,
  output logic                   padout_sram_oe_n,
  output logic                   padout_sram_we_n,
  output logic [N_SRAM_DQ/8-1:0] padout_sram_byte_n
);

  localparam int N_BYTE = N_SRAM_DQ / 8;

  phy_state_e            state_q, state_d;
  logic [W_TIMING-1:0]   cnt_q, cnt_d;
  logic                  capture;
  logic                  accept;

  logic                  write_q;
  logic [N_SRAM_A-1:0]   addr_q;
  logic [N_SRAM_DQ-1:0]  wdata_q;
  logic [N_BYTE-1:0]     byte_n_q;
  logic [W_TIMING-1:0]   strobe_q;
  logic [W_TIMING-1:0]   hold_q;

  logic                  txn_write;
  logic [N_SRAM_A-1:0]   txn_addr;
  logic [N_SRAM_DQ-1:0]  txn_wdata;
  logic [N_BYTE-1:0]     txn_byte_n;

  logic                  cs_n_q, cs_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [N_BYTE-1:0]     byte_n_q_pad, byte_n_d_pad;
  logic [N_SRAM_DQ-1:0]  padoe_q, padoe_d;
  logic [N_SRAM_DQ-1:0]  dq_q, dq_d;
  logic [N_SRAM_A-1:0]   a_q, a_d;
  logic                  rsp_valid_q;
  logic [N_SRAM_DQ-1:0]  rdata_q;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = (state_q == ST_IDLE) && req_valid;

  // The cycle a request is accepted the latched copy is not loaded yet, so pads take it from req_*.
  assign txn_write  = accept ? req_write  : write_q;
  assign txn_addr   = accept ? req_addr   : addr_q;
  assign txn_wdata  = accept ? req_wdata  : wdata_q;
  assign txn_byte_n = accept ? req_byte_n : byte_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (cfg_setup != '0) begin
            state_d = ST_SETUP;
            cnt_d   = cfg_setup - 1'b1;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = cfg_strobe;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = strobe_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          capture = !write_q;
          if (hold_q != '0) begin
            state_d = ST_HOLD;
            cnt_d   = hold_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad values are decoded from the next state so the pad flops line up with the state register.
  always_comb begin
    cs_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    byte_n_d_pad = '1;
    padoe_d      = '0;
    dq_d         = dq_q;
    a_d          = a_q;
    if (state_d != ST_IDLE) begin
      cs_n_d       = 1'b0;
      a_d          = txn_addr;
      byte_n_d_pad = txn_byte_n;
      if (txn_write) begin
        padoe_d = '1;
        dq_d    = txn_wdata;
      end
      if (state_d == ST_STROBE) begin
        oe_n_d = txn_write;
        we_n_d = !txn_write;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      byte_n_q <= req_byte_n;
      strobe_q <= cfg_strobe;
      hold_q   <= cfg_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      byte_n_q_pad <= '1;
      padoe_q      <= '0;
      dq_q         <= '0;
      a_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rdata_q      <= '0;
    end else begin
      cs_n_q       <= cs_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      byte_n_q_pad <= byte_n_d_pad;
      padoe_q      <= padoe_d;
      dq_q         <= dq_d;
      a_q          <= a_d;
      rsp_valid_q  <= capture;
      if (capture) begin
        rdata_q <= padin_sram_dq;
      end
    end
  end

  assign padout_sram_cs_n   = cs_n_q;
  assign padout_sram_oe_n   = oe_n_q;
  assign padout_sram_we_n   = we_n_q;
  assign padout_sram_byte_n = byte_n_q_pad;
  assign padoe_sram_dq      = padoe_q;
  assign padout_sram_dq     = dq_q;
  assign padout_sram_a      = a_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rdata_q;

endmodule

// File: tb/tb_async_sram_phy_seq.sv
// Directed bench for async_sram_phy_seq: a 16-bit and an 8-bit instance, each with a small SRAM model.
module tb_async_sram_phy_seq;
  import async_sram_phy_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  cfg_setup, cfg_strobe, cfg_hold;
  logic        req_valid, req_write, req_ready, rsp_valid;
  logic [17:0] req_addr, pa;
  logic [15:0] req_wdata, rsp_rdata, padin, dq, padoe;
  logic [1:0]  req_byte_n, byte_n;
  logic        cs_n, oe_n, we_n;

  logic [3:0]  cfg8_setup, cfg8_strobe, cfg8_hold;
  logic        req_valid8, req_write8, req_ready8, rsp_valid8;
  logic [17:0] req_addr8, pa8;
  logic [7:0]  req_wdata8, rsp_rdata8, padin8, dq8, padoe8;
  logic [0:0]  req_byte_n8, byte_n8;
  logic        cs_n8, oe_n8, we_n8;

  async_sram_phy_seq #(.N_SRAM_A(18), .N_SRAM_DQ(16), .W_TIMING(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .cfg_setup(cfg_setup), .cfg_strobe(cfg_strobe), .cfg_hold(cfg_hold),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_n(req_byte_n),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .padin_sram_dq(padin), .padout_sram_dq(dq), .padoe_sram_dq(padoe),
    .padout_sram_a(pa), .padout_sram_cs_n(cs_n), .padout_sram_oe_n(oe_n),
    .padout_sram_we_n(we_n), .padout_sram_byte_n(byte_n)
  );

  async_sram_phy_seq #(.N_SRAM_A(18), .N_SRAM_DQ(8), .W_TIMING(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .cfg_setup(cfg8_setup), .cfg_strobe(cfg8_strobe), .cfg_hold(cfg8_hold),
    .req_valid(req_valid8), .req_ready(req_ready8), .req_write(req_write8),
    .req_addr(req_addr8), .req_wdata(req_wdata8), .req_byte_n(req_byte_n8),
    .rsp_valid(rsp_valid8), .rsp_rdata(rsp_rdata8),
    .padin_sram_dq(padin8), .padout_sram_dq(dq8), .padoe_sram_dq(padoe8),
    .padout_sram_a(pa8), .padout_sram_cs_n(cs_n8), .padout_sram_oe_n(oe_n8),
    .padout_sram_we_n(we_n8), .padout_sram_byte_n(byte_n8)
  );

  // SRAM models: combinational read while cs_n/oe_n low, byte-lane writes while cs_n/we_n low.
  logic [15:0] mem16 [256];
  logic [7:0]  mem8  [256];
  logic        pl16_en = 1'b0, pl8_en = 1'b0;
  logic [7:0]  pl16_addr, pl8_addr;
  logic [15:0] pl16_data;
  logic [7:0]  pl8_data;

  assign padin  = (!cs_n  && !oe_n)  ? mem16[pa[7:0]]  : 16'h0000;
  assign padin8 = (!cs_n8 && !oe_n8) ? mem8[pa8[7:0]]  : 8'h00;

  always @(negedge clk) begin
    if (pl16_en) mem16[pl16_addr] = pl16_data;
    if (pl8_en) mem8[pl8_addr] = pl8_data;
    if (!cs_n && !we_n) begin
      if (!byte_n[0]) mem16[pa[7:0]][7:0]  = dq[7:0];
      if (!byte_n[1]) mem16[pa[7:0]][15:8] = dq[15:8];
    end
    if (!cs_n8 && !we_n8 && !byte_n8[0]) mem8[pa8[7:0]] = dq8;
  end

  task automatic preload16(input logic [7:0] addr, input logic [15:0] data);
    pl16_addr = addr; pl16_data = data; pl16_en = 1'b1;
    @(negedge clk); #1 pl16_en = 1'b0;
  endtask

  task automatic preload8(input logic [7:0] addr, input logic [7:0] data);
    pl8_addr = addr; pl8_data = data; pl8_en = 1'b1;
    @(negedge clk); #1 pl8_en = 1'b0;
  endtask

  task automatic issue16(input logic wr, input logic [17:0] addr, input logic [15:0] wd,
                         input logic [1:0] bn);
    req_write = wr; req_addr = addr; req_wdata = wd; req_byte_n = bn; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    checks++; if ({oe_n, we_n} !== 2'b11) begin errors++; $display("FAIL reset_oe_we: got %b expected 11", {oe_n, we_n}); end
    checks++; if (byte_n !== 2'b11) begin errors++; $display("FAIL reset_byte_n: got %b expected 11", byte_n); end
    checks++; if (padoe !== 16'h0) begin errors++; $display("FAIL reset_padoe: got %h expected 0000", padoe); end
    checks++; if ({dq, pa} !== 34'h0) begin errors++; $display("FAIL reset_dq_a: got %h/%h expected 0/0", dq, pa); end
    checks++; if ({rsp_valid, rsp_rdata} !== 17'h0) begin errors++; $display("FAIL reset_rsp: got %b/%h expected 0/0000", rsp_valid, rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if ({cs_n8, oe_n8, we_n8, byte_n8, padoe8} !== {4'b1111, 8'h00}) begin errors++; $display("FAIL reset_dut8: got %b%b%b%b/%h expected 1111/00", cs_n8, oe_n8, we_n8, byte_n8, padoe8); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({req_ready, cs_n} !== 2'b11) begin errors++; $display("FAIL post_reset_idle: got %b expected 11", {req_ready, cs_n}); end
  endtask

  task automatic test_read();
    int cs_lo = 0, oe_lo = 0, rdy_lo = 0, rsp_n = 0;
    logic [15:0] got = 16'h0;
    logic [17:0] a_seen = 18'h0;
    preload16(8'h45, 16'hBEEF);
    cfg_setup = 4'd1; cfg_strobe = 4'd2; cfg_hold = 4'd1;
    issue16(1'b0, 18'h12345, 16'h0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!cs_n) begin cs_lo++; a_seen = pa; end
      if (!oe_n) oe_lo++;
      if (!req_ready) rdy_lo++;
      if (rsp_valid) begin rsp_n++; got = rsp_rdata; end
    end
    checks++; if (cs_lo != 5) begin errors++; $display("FAIL read_cs_len: got %0d expected 5", cs_lo); end
    checks++; if (oe_lo != 3) begin errors++; $display("FAIL read_oe_len: got %0d expected 3", oe_lo); end
    checks++; if (rdy_lo != 5) begin errors++; $display("FAIL read_ready_low: got %0d expected 5", rdy_lo); end
    checks++; if (rsp_n != 1) begin errors++; $display("FAIL read_rsp_pulses: got %0d expected 1", rsp_n); end
    checks++; if (got !== 16'hBEEF) begin errors++; $display("FAIL read_rdata: got %h expected beef", got); end
    checks++; if (a_seen !== 18'h12345) begin errors++; $display("FAIL read_addr: got %h expected 12345", a_seen); end
    checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata_hold: got %h expected beef", rsp_rdata); end
  endtask

  task automatic test_write();
    int cs_lo = 0, we_lo = 0, oe_bad = 0, rsp_n = 0, lane_bad = 0;
    preload16(8'h10, 16'h0000);
    cfg_setup = 4'd0; cfg_strobe = 4'd0; cfg_hold = 4'd0;
    issue16(1'b1, 18'h00010, 16'hA55A, 2'b01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!cs_n) begin
        cs_lo++;
        if (padoe !== 16'hFFFF || dq !== 16'hA55A || byte_n !== 2'b01) lane_bad++;
      end else if (padoe !== 16'h0) oe_bad++;
      if (!we_n) we_lo++;
      if (rsp_valid) rsp_n++;
    end
    checks++; if (we_lo != 1) begin errors++; $display("FAIL write_we_len: got %0d expected 1", we_lo); end
    checks++; if (cs_lo != 1) begin errors++; $display("FAIL write_cs_len: got %0d expected 1", cs_lo); end
    checks++; if (lane_bad != 0) begin errors++; $display("FAIL write_drive: got %0d bad cycles expected 0", lane_bad); end
    checks++; if (oe_bad != 0) begin errors++; $display("FAIL write_padoe_idle: got %0d cycles expected 0", oe_bad); end
    checks++; if (rsp_n != 0) begin errors++; $display("FAIL write_no_rsp: got %0d expected 0", rsp_n); end
    checks++; if (mem16[8'h10] !== 16'hA500) begin errors++; $display("FAIL write_mem: got %h expected a500", mem16[8'h10]); end
  endtask

  task automatic test_back_to_back();
    int periods = 0, gap = 0, overlap = 0, rsp_n = 0;
    logic prev_cs = 1'b1;
    preload16(8'h20, 16'h1111);
    preload16(8'h21, 16'h0000);
    cfg_setup = 4'd1; cfg_strobe = 4'd1; cfg_hold = 4'd0;
    req_write = 1'b0; req_addr = 18'h00020; req_wdata = 16'h0; req_byte_n = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 18'h00021; req_wdata = 16'h2468;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (prev_cs && !cs_n) periods++;
      prev_cs = cs_n;
      if (!oe_n && padoe != 16'h0) overlap++;
      if (rsp_valid) rsp_n++;
      if (periods == 1 && cs_n && oe_n && padoe == 16'h0) gap++;
      if (req_ready && periods == 1) begin
        @(posedge clk); #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (periods != 2) begin errors++; $display("FAIL b2b_periods: got %0d expected 2", periods); end
    checks++; if (gap != 1) begin errors++; $display("FAIL b2b_gap: got %0d expected 1", gap); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
    checks++; if (rsp_n != 1 || rsp_rdata !== 16'h1111) begin errors++; $display("FAIL b2b_read: got %0d/%h expected 1/1111", rsp_n, rsp_rdata); end
    checks++; if (mem16[8'h21] !== 16'h2468) begin errors++; $display("FAIL b2b_write: got %h expected 2468", mem16[8'h21]); end
  endtask

  task automatic test_cfg_change();
    int oe1 = 0, oe2 = 0, rsp_n = 0;
    preload16(8'h40, 16'h4444);
    cfg_setup = 4'd0; cfg_strobe = 4'd2; cfg_hold = 4'd0;
    issue16(1'b0, 18'h00040, 16'h0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!oe_n) oe1++;
      if (i == 0) cfg_strobe = 4'd7;
    end
    issue16(1'b0, 18'h00040, 16'h0, 2'b00);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!oe_n) oe2++;
      if (rsp_valid) rsp_n++;
    end
    checks++; if (oe1 != 3) begin errors++; $display("FAIL cfg_inflight_strobe: got %0d expected 3", oe1); end
    checks++; if (oe2 != 8) begin errors++; $display("FAIL cfg_next_strobe: got %0d expected 8", oe2); end
    checks++; if (rsp_n != 1 || rsp_rdata !== 16'h4444) begin errors++; $display("FAIL cfg_next_rsp: got %0d/%h expected 1/4444", rsp_n, rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    int waited = 0, rsp_n = 0, cs_lo = 0;
    preload16(8'h50, 16'h5555);
    preload16(8'h51, 16'h7A7A);
    cfg_setup = 4'd1; cfg_strobe = 4'd3; cfg_hold = 4'd1;
    issue16(1'b0, 18'h00050, 16'h0, 2'b00);
    while (oe_n && waited < 10) begin @(negedge clk); waited++; end
    checks++; if (oe_n !== 1'b0) begin errors++; $display("FAIL rstmid_reach_strobe: got oe_n %b expected 0 within 10 cycles", oe_n); end
    rst_n = 1'b0;
    #1;
    checks++; if ({cs_n, oe_n, we_n, byte_n} !== 5'b11111) begin errors++; $display("FAIL rstmid_strobes: got %b expected 11111", {cs_n, oe_n, we_n, byte_n}); end
    checks++; if (padoe !== 16'h0 || pa !== 18'h0) begin errors++; $display("FAIL rstmid_padoe_a: got %h/%h expected 0/0", padoe, pa); end
    checks++; if ({rsp_valid, rsp_rdata} !== 17'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_rsp_ready: got %b/%h/%b expected 0/0000/1", rsp_valid, rsp_rdata, req_ready); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid) rsp_n++; end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
      if (!cs_n) cs_lo++;
    end
    checks++; if (rsp_n != 0 || cs_lo != 0) begin errors++; $display("FAIL rstmid_dropped: got rsp %0d cs %0d expected 0 0", rsp_n, cs_lo); end
    cfg_setup = 4'd0; cfg_strobe = 4'd0; cfg_hold = 4'd0;
    issue16(1'b0, 18'h00051, 16'h0, 2'b00);
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (rsp_valid) rsp_n++; end
    checks++; if (rsp_n != 1 || rsp_rdata !== 16'h7A7A) begin errors++; $display("FAIL rstmid_next_read: got %0d/%h expected 1/7a7a", rsp_n, rsp_rdata); end
  endtask

  task automatic test_8bit();
    int setup_n = 0, oe_lo = 0, hold_n = 0, cs_lo = 0, rsp_n = 0, we_lo = 0;
    logic seen_oe = 1'b0;
    preload8(8'h05, 8'hC3);
    preload8(8'h06, 8'h00);
    cfg8_setup = 4'hF; cfg8_strobe = 4'hF; cfg8_hold = 4'hF;
    req_write8 = 1'b0; req_addr8 = 18'h00005; req_wdata8 = 8'h00; req_byte_n8 = 1'b0; req_valid8 = 1'b1;
    @(posedge clk); #1 req_valid8 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!cs_n8) cs_lo++;
      if (!oe_n8) begin oe_lo++; seen_oe = 1'b1; end
      else if (!cs_n8 && !seen_oe) setup_n++;
      else if (!cs_n8) hold_n++;
      if (rsp_valid8) rsp_n++;
    end
    checks++; if (setup_n != 15 || oe_lo != 16 || hold_n != 15) begin errors++; $display("FAIL b8_phases: got %0d/%0d/%0d expected 15/16/15", setup_n, oe_lo, hold_n); end
    checks++; if (cs_lo != 46) begin errors++; $display("FAIL b8_cs_len: got %0d expected 46", cs_lo); end
    checks++; if (rsp_n != 1 || rsp_rdata8 !== 8'hC3) begin errors++; $display("FAIL b8_read: got %0d/%h expected 1/c3", rsp_n, rsp_rdata8); end
    req_write8 = 1'b1; req_addr8 = 18'h00006; req_wdata8 = 8'h7E; req_valid8 = 1'b1;
    @(posedge clk); #1 req_valid8 = 1'b0;
    rsp_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!we_n8) we_lo++;
      if (rsp_valid8) rsp_n++;
    end
    checks++; if (we_lo != 16 || rsp_n != 0) begin errors++; $display("FAIL b8_write_strobe: got we %0d rsp %0d expected 16 0", we_lo, rsp_n); end
    checks++; if (mem8[8'h06] !== 8'h7E) begin errors++; $display("FAIL b8_write_mem: got %h expected 7e", mem8[8'h06]); end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_setup = '0; cfg_strobe = '0; cfg_hold = '0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_byte_n = '1;
    cfg8_setup = '0; cfg8_strobe = '0; cfg8_hold = '0;
    req_valid8 = 1'b0; req_write8 = 1'b0; req_addr8 = '0; req_wdata8 = '0; req_byte_n8 = '1;
    pl16_addr = '0; pl16_data = '0; pl8_addr = '0; pl8_data = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    test_8bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
